uart_rx: RTL

Serial receiver paired with the existing UART transmitter. It consumes the transmitter's 11-bit frame: start(0), 8 data bits LSB-first, even parity, stop(1). It sits between the asynchronous `rxd` pin and the byte-level logic. Each received byte is presented with a one-cycle valid pulse and per-byte error flags.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_rx_tick.sv | 18 +
 rtl/uart_rx.sv | 89 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, frame constants and parity helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
  localparam int DATA_BITS = 8;
  localparam bit PARITY_EVEN = 1'b1;
  localparam int STOP_BITS = 1;
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return ^d ^ ~PARITY_EVEN;
  endfunction
endpackage

// File: rtl/uart_rx_tick.sv
// uart_rx_tick: oversample tick divider, held at zero while cleared
module uart_rx_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = !clear && cnt == W'(DIV - 1);
  // count 0..DIV-1, restarting from 0 whenever cleared
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8E1 serial receiver with per-byte error flags
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);
  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV = DIV_RAW < 1 ? 1 : DIV_RAW;
  localparam int SW = $clog2(OVERSAMPLE);
  uart_state_e state;
  logic sync1, rxd_s, rxd_d, tick, pe;
  logic [SW-1:0] scnt;
  logic [2:0] bcnt;
  logic [DATA_BITS-1:0] shift;
  wire mid  = tick && scnt == SW'(OVERSAMPLE / 2 - 1);
  wire full = tick && scnt == SW'(OVERSAMPLE - 1);
  assign busy = state != IDLE || rx_valid;
  uart_rx_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(state == IDLE),
    .tick (tick)
  );
  // two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) {sync1, rxd_s, rxd_d} <= 3'b111;
    else {sync1, rxd_s, rxd_d} <= {rxd, sync1, rxd_s};
  end
  // frame FSM: mid-bit sampling of start, data, parity and stop bits
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      scnt       <= '0;
      bcnt       <= '0;
      shift      <= '0;
      pe         <= 1'b0;
      data_out   <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (tick) scnt <= scnt == SW'(OVERSAMPLE - 1) ? '0 : scnt + 1'b1;
      case (state)
        IDLE: begin
          scnt <= '0;
          bcnt <= '0;
          if (rxd_d && !rxd_s) state <= START;
        end
        START: if (mid) begin
          scnt  <= '0;
          state <= rxd_s ? IDLE : DATA;
        end
        DATA: if (full) begin
          shift <= {rxd_s, shift[DATA_BITS-1:1]};
          bcnt  <= bcnt + 1'b1;
          if (bcnt == 3'(DATA_BITS - 1)) state <= PARITY;
        end
        PARITY: if (full) begin
          pe    <= rxd_s ^ parity_bit(shift);
          bcnt  <= '0;
          state <= STOP;
        end
        STOP: if (full) begin
          bcnt <= bcnt + 1'b1;
          if (bcnt == 3'(STOP_BITS - 1)) begin
            data_out   <= shift;
            parity_err <= pe;
            frame_err  <= ~rxd_s;
            rx_valid   <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
